entry_alloc_queue: RTL and testbench
====================================

Name: entry_alloc_queue

Overview:
16-entry circular allocation tracker that produces the valid array and oldest pointer consumed by the shift-priority arbiter.
- Allocates entries in order at the tail.
- Tracks per-entry state: pending issue, issued, done.
- Retires done entries in order from the bottom pointer.
- Sits beside the arbiter in the miss/request queue: the arbiter reads and selects; this block writes and frees.

Parameters:
DEPTH, 16, number of entries; fixed at 16 to match the 16-bit arbiter interface.
PTR_W, 4, pointer width, log2(DEPTH).

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
alloc_vld_i  in  1  allocation request
alloc_rdy_o  out  1  queue can accept an allocation
alloc_ptr_o  out  4  entry index granted to the current allocation (tail pointer)
issue_vld_i  in  1  arbiter-selected entry issued this cycle
issue_ptr_i  in  4  issued entry index (arbiter select_ptr_o)
cmpl_vld_i  in  1  completion of an issued entry
cmpl_ptr_i  in  4  completed entry index
valid_array_o  out  16  bit n=1 iff entry n is PEND (arbiter valid_array_i)
bottom_ptr_o  out  4  oldest occupied entry (arbiter bottom_ptr_i)
retire_vld_o  out  1  bottom entry retired this cycle
retire_ptr_o  out  4  retired entry index
count_o  out  5  occupancy, 0..16
err_o  out  1  sticky protocol-violation flag

Behaviour:
- Per-entry state, 2 bits: FREE=0, PEND=1, ISSUED=2, DONE=3.
- Registered state: top_ptr, bottom_ptr, count.
- Reset:
  - all entries FREE; top_ptr=bottom_ptr=0; count=0; err_o=0.
  - Outputs during and after reset: valid_array_o=0, retire_vld_o=0, alloc_rdy_o=1.
- alloc_rdy_o = (count != 16), from registered count only.
- Allocation (alloc_vld_i & alloc_rdy_o):
  - entry[top_ptr] FREE->PEND; top_ptr+1 mod 16.
  - The entry is visible in valid_array_o the next cycle.
- alloc_vld_i while not ready: ignored, no error.
- Issue (issue_vld_i): entry[issue_ptr_i] PEND->ISSUED. If the entry is not PEND, state is unchanged and err_o is set.
- Completion (cmpl_vld_i): entry[cmpl_ptr_i] ISSUED->DONE. If the entry is not ISSUED, state is unchanged and err_o is set.
- Retire, combinational from registered state:
  - retire_vld_o = (count != 0) & entry[bottom_ptr]==DONE; retire_ptr_o = bottom_ptr.
  - On retire: entry FREE; bottom_ptr+1 mod 16, wrapping 15->0.
  - At most one retire per cycle.
  - A completion takes 1 cycle to become retirable.
- Count: count_next = count + alloc_fire - retire_vld_o.
  - Simultaneous alloc and retire: count unchanged, both pointers advance.
- Full (count=16): top_ptr==bottom_ptr. Alloc is blocked even if a retire occurs the same cycle.
- Empty (count=0): top_ptr==bottom_ptr; valid_array_o=0; retire_vld_o=0.
- Same-cycle issue and cmpl on the same index: issue applies, cmpl sees a non-ISSUED entry and flags err_o.
- Issue and alloc on the same index in one cycle is impossible without error (the entry is FREE before alloc), so issue flags err_o.
- err_o clears only on reset.
- Reset mid-operation discards all entries without retire pulses.

Optional Feature:
Macro ENTRY_ALLOC_QUEUE_REPLAY_EN.
- Defined: adds ports replay_vld_i (1) and replay_ptr_i (4). Replay moves entry ISSUED->PEND so the arbiter re-selects it. Replay of a non-ISSUED entry sets err_o. Replay and cmpl on the same index in the same cycle: cmpl wins, replay flags err_o.
- Undefined: ports absent; ISSUED leaves only via completion.

Decomposition:
- Shared package mcash_queue_pkg holds:
  - entry-state typedef/localparams FREE/PEND/ISSUED/DONE;
  - QUEUE_DEPTH=16 and QUEUE_PTR_W=4, also used by the arbiter.
- One natural sub-module: entry_state_cell, a single-entry 2-bit state register with alloc/issue/cmpl/replay/retire inputs and an error output, instantiated 16 times. The top level holds pointers, count and the error OR-reduce.

Test Plan:
1. Reset, then 3 allocs on consecutive cycles -> alloc_ptr_o 0,1,2; next cycle valid_array_o=16'h0007, count_o=3, bottom_ptr_o=0.
2. Issue 1, cmpl 1, issue 0, cmpl 0 -> no retire while entry 0 is ISSUED. The cycle after entry 0 is DONE: retire_ptr_o=0, then next cycle retire_ptr_o=1; bottom_ptr_o=2; count_o=1.
3. Fill 16 entries -> alloc_rdy_o=0, count_o=16. Further alloc_vld_i is ignored, and an alloc in the same cycle as a retire is still refused. The cycle after the retire, alloc_rdy_o=1.
4. Wrap: bottom_ptr=14, entries 14,15,0 allocated -> valid_array_o=16'hC001. Retire sequence 14,15,0 leaves bottom_ptr_o=1.
5. Protocol errors: cmpl on a PEND entry 5 -> err_o=1 next cycle, entry 5 still PEND. Issue on a FREE entry -> err_o stays 1 until rst_i.
6. With ENTRY_ALLOC_QUEUE_REPLAY_EN: issue 3, replay 3 -> valid_array_o bit 3 returns to 1 next cycle. Replay and cmpl both on entry 3 in one cycle -> entry DONE, err_o=1.

Source files
------------

// File: rtl/mcash_queue_pkg.sv
// Shared definitions for the miss/request queue: entry states and queue geometry.
// Also used by the shift-priority arbiter.
package mcash_queue_pkg;

   localparam int QUEUE_DEPTH = 16;
   localparam int QUEUE_PTR_W = 4;
   localparam int QUEUE_CNT_W = 5;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      PEND   = 2'd1,
      ISSUED = 2'd2,
      DONE   = 2'd3
   } entry_state_t;

   function automatic logic [QUEUE_PTR_W-1:0] ptr_inc(input logic [QUEUE_PTR_W-1:0] ptr);
      return ptr + 4'd1;
   endfunction

endpackage

// File: rtl/entry_alloc_queue_if.sv
// Handshake bundle between the allocation queue and its users (allocator, arbiter, completion path).
// Replay signals exist only when ENTRY_ALLOC_QUEUE_REPLAY_EN is defined.
interface entry_alloc_queue_if;
   import mcash_queue_pkg::*;

   logic                   alloc_vld_i;
   logic                   alloc_rdy_o;
   logic [QUEUE_PTR_W-1:0] alloc_ptr_o;
   logic                   issue_vld_i;
   logic [QUEUE_PTR_W-1:0] issue_ptr_i;
   logic                   cmpl_vld_i;
   logic [QUEUE_PTR_W-1:0] cmpl_ptr_i;
`ifdef ENTRY_ALLOC_QUEUE_REPLAY_EN
   logic                   replay_vld_i;
   logic [QUEUE_PTR_W-1:0] replay_ptr_i;
`endif
   logic [QUEUE_DEPTH-1:0] valid_array_o;
   logic [QUEUE_PTR_W-1:0] bottom_ptr_o;
   logic                   retire_vld_o;
   logic [QUEUE_PTR_W-1:0] retire_ptr_o;
   logic [QUEUE_CNT_W-1:0] count_o;
   logic                   err_o;

   modport slave (
`ifdef ENTRY_ALLOC_QUEUE_REPLAY_EN
      input  replay_vld_i, replay_ptr_i,
`endif
      input  alloc_vld_i, issue_vld_i, issue_ptr_i, cmpl_vld_i, cmpl_ptr_i,
      output alloc_rdy_o, alloc_ptr_o, valid_array_o, bottom_ptr_o,
             retire_vld_o, retire_ptr_o, count_o, err_o
   );

   modport master (
`ifdef ENTRY_ALLOC_QUEUE_REPLAY_EN
      output replay_vld_i, replay_ptr_i,
`endif
      output alloc_vld_i, issue_vld_i, issue_ptr_i, cmpl_vld_i, cmpl_ptr_i,
      input  alloc_rdy_o, alloc_ptr_o, valid_array_o, bottom_ptr_o,
             retire_vld_o, retire_ptr_o, count_o, err_o
   );

endinterface

// File: rtl/entry_state_cell.sv
// One queue entry: 2-bit lifecycle state FREE->PEND->ISSUED->DONE->FREE with
// a per-cycle illegal-transition indication (made sticky by the parent).
module entry_state_cell
   import mcash_queue_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         alloc_i,
   input  logic         issue_i,
   input  logic         cmpl_i,
   input  logic         replay_i,
   input  logic         retire_i,
   output entry_state_t state_o,
   output logic         err_o
);

   entry_state_t state_r;
   entry_state_t state_nxt_s;

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= FREE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state: each request only acts on its legal source state; completion beats replay
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         FREE: begin
            if (alloc_i) state_nxt_s = PEND;
            else         state_nxt_s = state_r;
         end
         PEND: begin
            if (issue_i) state_nxt_s = ISSUED;
            else         state_nxt_s = state_r;
         end
         ISSUED: begin
            if (cmpl_i)        state_nxt_s = DONE;
            else if (replay_i) state_nxt_s = PEND;
            else               state_nxt_s = state_r;
         end
         DONE: begin
            if (retire_i) state_nxt_s = FREE;
            else          state_nxt_s = state_r;
         end
         default: state_nxt_s = FREE;
      endcase
   end

   // Protocol error, judged against the state held at the start of the cycle
   always_comb begin
      err_o = (issue_i  && (state_r != PEND))   ||
              (cmpl_i   && (state_r != ISSUED)) ||
              (replay_i && ((state_r != ISSUED) || cmpl_i));
   end

   assign state_o = state_r;

endmodule

// File: rtl/entry_alloc_queue.sv
// 16-entry circular allocation tracker feeding the shift-priority arbiter.
// Optional replay path enabled by ENTRY_ALLOC_QUEUE_REPLAY_EN.
module entry_alloc_queue
   import mcash_queue_pkg::*;
#(
   parameter int DEPTH = QUEUE_DEPTH,
   parameter int PTR_W = QUEUE_PTR_W
)
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   entry_alloc_queue_if.slave   bus
);

   logic [PTR_W-1:0]       top_ptr_r;
   logic [PTR_W-1:0]       bottom_ptr_r;
   logic [QUEUE_CNT_W-1:0] count_r;
   logic [QUEUE_CNT_W-1:0] count_nxt_s;
   logic                   err_r;

   entry_state_t           state_s [DEPTH];
   logic [DEPTH-1:0]       cell_err_s;
   logic [DEPTH-1:0]       pend_s;
   logic                   not_full_s;
   logic                   alloc_fire_s;
   logic                   retire_vld_s;
   logic                   replay_vld_s;
   logic [PTR_W-1:0]       replay_ptr_s;

`ifdef ENTRY_ALLOC_QUEUE_REPLAY_EN
   assign replay_vld_s = bus.replay_vld_i;
   assign replay_ptr_s = bus.replay_ptr_i;
`else
   assign replay_vld_s = 1'b0;
   assign replay_ptr_s = {PTR_W{1'b0}};
`endif

   // Readiness comes only from the registered count, so a same-cycle retire cannot unblock a full queue
   assign not_full_s   = (count_r != 5'd16);
   assign alloc_fire_s = bus.alloc_vld_i && not_full_s && !rst_i;
   assign retire_vld_s = !rst_i && (count_r != 5'd0) && (state_s[bottom_ptr_r] == DONE);

   for (genvar n = 0; n < DEPTH; n++) begin : g_entry
      entry_state_cell u_cell (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .alloc_i  (alloc_fire_s && (top_ptr_r == PTR_W'(n))),
         .issue_i  (bus.issue_vld_i && (bus.issue_ptr_i == PTR_W'(n))),
         .cmpl_i   (bus.cmpl_vld_i && (bus.cmpl_ptr_i == PTR_W'(n))),
         .replay_i (replay_vld_s && (replay_ptr_s == PTR_W'(n))),
         .retire_i (retire_vld_s && (bottom_ptr_r == PTR_W'(n))),
         .state_o  (state_s[n]),
         .err_o    (cell_err_s[n])
      );
      assign pend_s[n] = (state_s[n] == PEND);
   end

   // Occupancy update: alloc and retire in the same cycle cancel out
   always_comb begin
      count_nxt_s = count_r;
      case ({alloc_fire_s, retire_vld_s})
         2'b10:   count_nxt_s = count_r + 5'd1;
         2'b01:   count_nxt_s = count_r - 5'd1;
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointers, occupancy and sticky error flag
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         top_ptr_r    <= {PTR_W{1'b0}};
         bottom_ptr_r <= {PTR_W{1'b0}};
         count_r      <= 5'd0;
         err_r        <= 1'b0;
      end else begin
         if (alloc_fire_s) top_ptr_r    <= ptr_inc(top_ptr_r);
         if (retire_vld_s) bottom_ptr_r <= ptr_inc(bottom_ptr_r);
         count_r <= count_nxt_s;
         err_r   <= err_r | (|cell_err_s);
      end
   end

   assign bus.alloc_rdy_o   = rst_i || not_full_s;
   assign bus.alloc_ptr_o   = top_ptr_r;
   assign bus.valid_array_o = rst_i ? {DEPTH{1'b0}} : pend_s;
   assign bus.bottom_ptr_o  = bottom_ptr_r;
   assign bus.retire_vld_o  = retire_vld_s;
   assign bus.retire_ptr_o  = bottom_ptr_r;
   assign bus.count_o       = count_r;
   assign bus.err_o         = err_r;

endmodule

// File: tb/tb_entry_alloc_queue.sv
// Self-checking bench for entry_alloc_queue: directed table, corner sequences and
// randomized traffic against an occupancy-based reference model.
module tb_entry_alloc_queue;

   localparam int S_FREE = 0, S_PEND = 1, S_ISS = 2, S_DONE = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   entry_alloc_queue_if bus();
   entry_alloc_queue dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   int total = 0;
   int bad   = 0;

   int m_st [16];
   int m_head;
   int m_occ;
   bit m_err;

   typedef struct {
      int a; int i; int ip; int c; int cp;
      int rdy; int aptr; logic [15:0] valid; int bot; int ret; int rptr; int cnt; int err;
   } vec_t;
   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] m_valid();
      logic [15:0] v = 16'h0000;
      for (int k = 0; k < 16; k++) v[k] = (m_st[k] == S_PEND);
      return v;
   endfunction

   function automatic bit m_retire();
      return (m_occ != 0) && (m_st[m_head] == S_DONE);
   endfunction

   task automatic check_model();
      chk("rdy",    32'(bus.alloc_rdy_o),   32'(m_occ != 16));
      chk("aptr",   32'(bus.alloc_ptr_o),   32'((m_head + m_occ) % 16));
      chk("valid",  32'(bus.valid_array_o), 32'(m_valid()));
      chk("bottom", 32'(bus.bottom_ptr_o),  32'(m_head));
      chk("retire", 32'(bus.retire_vld_o),  32'(m_retire()));
      chk("rptr",   32'(bus.retire_ptr_o),  32'(m_head));
      chk("count",  32'(bus.count_o),       32'(m_occ));
      chk("err",    32'(bus.err_o),         32'(m_err));
   endtask

   task automatic model_step(input bit a, input bit i, input int ip, input bit c, input int cp,
                             input bit r, input int rp);
      int ns [16];
      bit fire;
      bit ret;
      ns   = m_st;
      fire = a && (m_occ < 16);
      ret  = m_retire();
      if (ret)  ns[m_head] = S_FREE;
      if (fire) ns[(m_head + m_occ) % 16] = S_PEND;
      if (i) begin
         if (m_st[ip] == S_PEND) ns[ip] = S_ISS; else m_err = 1'b1;
      end
      if (c) begin
         if (m_st[cp] == S_ISS) ns[cp] = S_DONE; else m_err = 1'b1;
      end
      if (r) begin
         if (m_st[rp] == S_ISS && !(c && cp == rp)) ns[rp] = S_PEND; else m_err = 1'b1;
      end
      m_st  = ns;
      m_occ = m_occ + int'(fire) - int'(ret);
      if (ret) m_head = (m_head + 1) % 16;
   endtask

   // Called at a falling edge: check the current outputs, apply inputs, advance one clock.
   task automatic drive_cycle(input bit a, input bit i, input int ip, input bit c, input int cp,
                              input bit r, input int rp);
      check_model();
      bus.alloc_vld_i = a;
      bus.issue_vld_i = i;
      bus.issue_ptr_i = 4'(ip);
      bus.cmpl_vld_i  = c;
      bus.cmpl_ptr_i  = 4'(cp);
`ifdef ENTRY_ALLOC_QUEUE_REPLAY_EN
      bus.replay_vld_i = r;
      bus.replay_ptr_i = 4'(rp);
`endif
      model_step(a, i, ip, c, cp, r, rp);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive_cycle(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.alloc_vld_i = 1'b0;
      bus.issue_vld_i = 1'b0;
      bus.issue_ptr_i = 4'd0;
      bus.cmpl_vld_i  = 1'b0;
      bus.cmpl_ptr_i  = 4'd0;
`ifdef ENTRY_ALLOC_QUEUE_REPLAY_EN
      bus.replay_vld_i = 1'b0;
      bus.replay_ptr_i = 4'd0;
`endif
      #1;
      chk("in_rst_valid",  32'(bus.valid_array_o), 32'd0);
      chk("in_rst_retire", 32'(bus.retire_vld_o),  32'd0);
      chk("in_rst_rdy",    32'(bus.alloc_rdy_o),   32'd1);
      for (int k = 0; k < 16; k++) m_st[k] = S_FREE;
      m_head = 0;
      m_occ  = 0;
      m_err  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic rand_run(input int n, input bit allow_bad);
      for (int k = 0; k < n; k++) begin
         int pq [$];
         int iq [$];
         bit a, i, c, r;
         int ip, cp, rp;
         for (int e = 0; e < 16; e++) begin
            if (m_st[e] == S_PEND) pq.push_back(e);
            if (m_st[e] == S_ISS)  iq.push_back(e);
         end
         a = ($urandom_range(0, 3) != 0);
         i = 1'b0; ip = 0; c = 1'b0; cp = 0; r = 1'b0; rp = 0;
         if (pq.size() > 0 && $urandom_range(0, 1) == 1) begin
            i = 1'b1; ip = pq[$urandom_range(0, pq.size() - 1)];
         end
         if (iq.size() > 0 && $urandom_range(0, 1) == 1) begin
            c = 1'b1; cp = iq[$urandom_range(0, iq.size() - 1)];
         end
`ifdef ENTRY_ALLOC_QUEUE_REPLAY_EN
         if (iq.size() > 0 && $urandom_range(0, 5) == 0) begin
            r = 1'b1; rp = iq[$urandom_range(0, iq.size() - 1)];
            if (!allow_bad && c && cp == rp) r = 1'b0;
         end
`endif
         if (allow_bad && $urandom_range(0, 31) == 0) begin
            i = 1'b1; ip = $urandom_range(0, 15);
         end
         if (allow_bad && $urandom_range(0, 31) == 0) begin
            c = 1'b1; cp = $urandom_range(0, 15);
         end
         drive_cycle(a, i, ip, c, cp, r, rp);
      end
   endtask

   initial begin
      // a, i, ip, c, cp | rdy, aptr, valid, bottom, retire, rptr, count, err
      tbl[0] = '{1, 0, 0, 0, 0,  1, 0, 16'h0000, 0, 0, 0, 0, 0};
      tbl[1] = '{1, 0, 0, 0, 0,  1, 1, 16'h0001, 0, 0, 0, 1, 0};
      tbl[2] = '{1, 0, 0, 0, 0,  1, 2, 16'h0003, 0, 0, 0, 2, 0};
      tbl[3] = '{0, 1, 1, 0, 0,  1, 3, 16'h0007, 0, 0, 0, 3, 0};
      tbl[4] = '{0, 0, 0, 1, 1,  1, 3, 16'h0005, 0, 0, 0, 3, 0};
      tbl[5] = '{0, 1, 0, 0, 0,  1, 3, 16'h0005, 0, 0, 0, 3, 0};
      tbl[6] = '{0, 0, 0, 1, 0,  1, 3, 16'h0004, 0, 0, 0, 3, 0};
      tbl[7] = '{0, 0, 0, 0, 0,  1, 3, 16'h0004, 0, 1, 0, 3, 0};
      tbl[8] = '{0, 0, 0, 0, 0,  1, 3, 16'h0004, 1, 1, 1, 2, 0};
      tbl[9] = '{0, 0, 0, 0, 0,  1, 3, 16'h0004, 2, 0, 2, 1, 0};

      @(negedge clk);
      do_reset();

      // Directed allocate / issue / complete / in-order retire
      for (int r = 0; r < 10; r++) begin
         chk("tbl_rdy",    32'(bus.alloc_rdy_o),   32'(tbl[r].rdy));
         chk("tbl_aptr",   32'(bus.alloc_ptr_o),   32'(tbl[r].aptr));
         chk("tbl_valid",  32'(bus.valid_array_o), 32'(tbl[r].valid));
         chk("tbl_bottom", 32'(bus.bottom_ptr_o),  32'(tbl[r].bot));
         chk("tbl_retire", 32'(bus.retire_vld_o),  32'(tbl[r].ret));
         chk("tbl_rptr",   32'(bus.retire_ptr_o),  32'(tbl[r].rptr));
         chk("tbl_count",  32'(bus.count_o),       32'(tbl[r].cnt));
         chk("tbl_err",    32'(bus.err_o),         32'(tbl[r].err));
         drive_cycle(tbl[r].a != 0, tbl[r].i != 0, tbl[r].ip, tbl[r].c != 0, tbl[r].cp, 1'b0, 0);
      end
      chk("after_tbl_count", 32'(bus.count_o), 32'd1);

      // Full queue: extra allocs ignored, alloc alongside retire still refused
      for (int k = 0; k < 15; k++) drive_cycle(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
      chk("full_rdy",   32'(bus.alloc_rdy_o), 32'd0);
      chk("full_count", 32'(bus.count_o),     32'd16);
      drive_cycle(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
      chk("full_ignored", 32'(bus.count_o), 32'd16);
      drive_cycle(1'b0, 1'b1, 2, 1'b0, 0, 1'b0, 0);
      drive_cycle(1'b0, 1'b0, 0, 1'b1, 2, 1'b0, 0);
      chk("full_retire_vld", 32'(bus.retire_vld_o), 32'd1);
      chk("full_retire_rdy", 32'(bus.alloc_rdy_o),  32'd0);
      drive_cycle(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
      chk("full_after_count", 32'(bus.count_o),      32'd15);
      chk("full_after_rdy",   32'(bus.alloc_rdy_o),  32'd1);
      chk("full_after_bot",   32'(bus.bottom_ptr_o), 32'd3);
      chk("full_after_aptr",  32'(bus.alloc_ptr_o),  32'd2);

      // Pointer wrap 14,15,0
      do_reset();
      for (int k = 0; k < 14; k++) drive_cycle(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
      for (int k = 0; k < 14; k++) drive_cycle(1'b0, 1'b1, k, 1'b0, 0, 1'b0, 0);
      for (int k = 0; k < 14; k++) drive_cycle(1'b0, 1'b0, 0, 1'b1, k, 1'b0, 0);
      idle(2);
      chk("wrap_pre_bot",   32'(bus.bottom_ptr_o), 32'd14);
      chk("wrap_pre_count", 32'(bus.count_o),      32'd0);
      for (int k = 0; k < 3; k++) drive_cycle(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
      chk("wrap_valid", 32'(bus.valid_array_o), 32'h0000C001);
      drive_cycle(1'b0, 1'b1, 14, 1'b0, 0, 1'b0, 0);
      drive_cycle(1'b0, 1'b1, 15, 1'b0, 0, 1'b0, 0);
      drive_cycle(1'b0, 1'b1, 0,  1'b1, 14, 1'b0, 0);
      chk("wrap_ret14", 32'(bus.retire_ptr_o), 32'd14);
      drive_cycle(1'b0, 1'b0, 0, 1'b1, 15, 1'b0, 0);
      chk("wrap_ret15", 32'(bus.retire_ptr_o), 32'd15);
      drive_cycle(1'b0, 1'b0, 0, 1'b1, 0, 1'b0, 0);
      chk("wrap_ret0_vld", 32'(bus.retire_vld_o), 32'd1);
      chk("wrap_ret0",     32'(bus.retire_ptr_o), 32'd0);
      idle(1);
      chk("wrap_post_bot", 32'(bus.bottom_ptr_o), 32'd1);

      // Protocol errors are sticky until reset
      for (int k = 0; k < 6; k++) drive_cycle(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
      drive_cycle(1'b0, 1'b0, 0, 1'b1, 5, 1'b0, 0);
      chk("err_cmpl_pend", 32'(bus.err_o),            32'd1);
      chk("err_still_pend", 32'(bus.valid_array_o[5]), 32'd1);
      drive_cycle(1'b0, 1'b1, 10, 1'b0, 0, 1'b0, 0);
      idle(2);
      chk("err_sticky", 32'(bus.err_o), 32'd1);
      do_reset();
      chk("err_cleared", 32'(bus.err_o), 32'd0);

`ifdef ENTRY_ALLOC_QUEUE_REPLAY_EN
      // Replay returns an issued entry to pending; completion beats a same-cycle replay
      for (int k = 0; k < 4; k++) drive_cycle(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
      drive_cycle(1'b0, 1'b1, 3, 1'b0, 0, 1'b0, 0);
      chk("replay_issued", 32'(bus.valid_array_o[3]), 32'd0);
      drive_cycle(1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 3);
      chk("replay_back", 32'(bus.valid_array_o[3]), 32'd1);
      chk("replay_ok",   32'(bus.err_o),            32'd0);
      drive_cycle(1'b0, 1'b1, 3, 1'b0, 0, 1'b0, 0);
      drive_cycle(1'b0, 1'b0, 0, 1'b1, 3, 1'b1, 3);
      chk("replay_cmpl_err", 32'(bus.err_o),            32'd1);
      chk("replay_cmpl_done", 32'(bus.valid_array_o[3]), 32'd0);
      idle(2);
      do_reset();
`endif

      // Randomized traffic: legal first, then with occasional protocol violations
      rand_run(500, 1'b0);
      chk("rand_legal_err", 32'(bus.err_o), 32'd0);
      do_reset();
      rand_run(500, 1'b1);

      // Reset mid-operation discards everything without retire pulses
      do_reset();
      chk("midrst_count",  32'(bus.count_o),       32'd0);
      chk("midrst_retire", 32'(bus.retire_vld_o),  32'd0);
      chk("midrst_valid",  32'(bus.valid_array_o), 32'd0);
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
